hpi_responder: RTL and testbench
================================

HPI_RESPONDER -- requirements
Module: hpi_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port hpi_addr, input, 2 bits: register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS).
REQ-004 SHALL have ports hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n, inputs, 1 bit each: active-low chip select, read strobe, write strobe and host-side reset.
REQ-005 SHALL have port hpi_data_in, input, 16 bits: host write data.
REQ-006 SHALL have ports hpi_data_out, output, 16 bits, and hpi_data_oe, output, 1 bit: read data and its drive enable.
REQ-007 SHALL have ports mbx_in_data, output, 16 bits; mbx_in_valid, output, 1 bit; mbx_in_ack, input, 1 bit: host-to-local mailbox.
REQ-008 SHALL have ports mbx_out_data, input, 16 bits, and mbx_out_wr, input, 1 bit: local-to-host mailbox.

Function
REQ-009 SHALL treat a cycle as a read when hpi_cs_n=0, hpi_r_n=0 and hpi_w_n=1, and as a write when hpi_cs_n=0, hpi_w_n=0 and hpi_r_n=1; cs_n=0 with r_n=w_n=0 SHALL cause no side effect and hold hpi_data_oe=0.
REQ-010 SHALL register the previous strobe state and act once per strobe, on the first active cycle only (edge detect); a strobe held for N cycles SHALL equal a single access.
REQ-011 SHALL contain 1024x16 RAM indexed by ADDRESS[10:1]; ADDRESS[0] and ADDRESS[15:11] SHALL be ignored for indexing (aliasing).
REQ-012 Write to DATA SHALL store hpi_data_in at RAM[ADDRESS[10:1]] on the edge-detected cycle.
REQ-013 Read of any register SHALL present its value on hpi_data_out and set hpi_data_oe=1 on the cycle after the edge-detected cycle; both SHALL hold until the cycle after the strobe or hpi_cs_n deasserts, after which hpi_data_oe=0.
REQ-014 Write to ADDRESS SHALL load hpi_data_in; a read of ADDRESS SHALL return the current value.
REQ-015 Host write to MAILBOX SHALL load mbx_in_data and set mbx_in_valid=1; mbx_in_ack=1 SHALL clear mbx_in_valid; a host write coinciding with ack SHALL leave mbx_in_valid=1 with the new data.
REQ-016 mbx_out_wr=1 SHALL latch mbx_out_data into the outbound mailbox and set the OUT flag; a host read of MAILBOX SHALL return the outbound value and clear the OUT flag at strobe end; mbx_out_wr on the same cycle as that clear SHALL win, leaving OUT=1 with the new data.
REQ-017 STATUS SHALL be read-only: bit0=OUT flag, bit1=mbx_in_valid, bits[15:2]=0; writes to STATUS SHALL be ignored.
REQ-018 hpi_rst_n=0 SHALL clear ADDRESS, the OUT flag and mbx_in_valid and abort any access in progress; RAM contents SHALL be retained.

Reset
REQ-019 reset_n=0 SHALL force hpi_data_out=0x0000, hpi_data_oe=0, mbx_in_data=0x0000, mbx_in_valid=0, ADDRESS=0x0000, OUT flag=0 and strobe history=inactive; RAM SHALL NOT be initialised.
REQ-020 reset_n=0 asserted during a held strobe SHALL abort the access; after release, the still-held strobe SHALL count as a new access only after it deasserts and reasserts.

Configuration
REQ-021 With HPI_AUTOINC_EN defined, ADDRESS SHALL increment by 2 modulo 2^16 (0xFFFE -> 0x0000) at the end of each DATA read strobe and on the cycle after each DATA write commit; without it, ADDRESS SHALL change only on host writes to ADDRESS or on either reset.

Verification
REQ-022 Write ADDRESS=0x0100, write DATA=0xBEEF, write ADDRESS=0x0100, read DATA -> hpi_data_out=0xBEEF one cycle after the strobe edge, with hpi_data_oe=1.
REQ-023 HPI_AUTOINC_EN: ADDRESS=0xFFFE, write DATA 0x1111 then 0x2222 -> ADDRESS=0x0002, RAM[1023]=0x1111, RAM[0]=0x2222; without the macro -> ADDRESS=0xFFFE, RAM[1023]=0x2222.
REQ-024 Write strobe held 10 cycles on DATA with autoinc -> exactly one RAM write, ADDRESS advances by 2 only.
REQ-025 Host write MAILBOX=0x00A5 in the same cycle as mbx_in_ack=1 -> mbx_in_valid=1, mbx_in_data=0x00A5; read STATUS -> 0x0002.
REQ-026 mbx_out_wr with 0x1234 -> STATUS=0x0001; host read MAILBOX -> 0x1234, STATUS then 0x0000; repeat with mbx_out_wr coinciding with the clear -> STATUS stays 0x0001.
REQ-027 hpi_cs_n=0, hpi_r_n=0 and hpi_w_n=0 on DATA -> hpi_data_oe=0, RAM and ADDRESS unchanged; pulse hpi_rst_n=0 -> ADDRESS=0, STATUS=0, RAM retained.

Source files
------------

// File: rtl/hpi_responder.sv
// hpi_responder: host-port-interface slave with a 1024x16 RAM, an address
// pointer, an inbound and an outbound mailbox, and a read-only status word.
//
// Optional feature: HPI_AUTOINC_EN -- when defined, ADDRESS advances by 2
// after each DATA access (end of a read strobe, cycle after a write commit).
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   hpi_addr[1:0]       register select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   hpi_cs_n, hpi_r_n,  active-low chip select, read and write strobes
//   hpi_w_n, hpi_rst_n  and host-side reset
//   hpi_data_in[15:0]   host write data
//   hpi_data_out[15:0]  read data, valid while hpi_data_oe=1
//   hpi_data_oe         read data drive enable
//   mbx_in_data/valid   host-to-local mailbox, mbx_in_ack clears valid
//   mbx_out_data/wr     local-to-host mailbox load
module hpi_responder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  hpi_addr,
  input  logic        hpi_cs_n,
  input  logic        hpi_r_n,
  input  logic        hpi_w_n,
  input  logic        hpi_rst_n,
  input  logic [15:0] hpi_data_in,
  output logic [15:0] hpi_data_out,
  output logic        hpi_data_oe,
  output logic [15:0] mbx_in_data,
  output logic        mbx_in_valid,
  input  logic        mbx_in_ack,
  input  logic [15:0] mbx_out_data,
  input  logic        mbx_out_wr
);

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned RAM_AW    = 10;
  localparam int unsigned RAM_DEPTH = 1 << RAM_AW;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_MBX    = 2'd1;
  localparam logic [1:0] REG_ADDR   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic              rd_q;
  logic              wr_q;
  logic              lock_q;
  logic [1:0]        rd_sel_q;
  logic [DATA_W-1:0] address_q;
  logic [DATA_W-1:0] mbx_out_q;
  logic              out_flag_q;

  logic              rd_act_c;
  logic              wr_act_c;
  logic              access_ok_c;
  logic              rd_edge_c;
  logic              wr_edge_c;
  logic              rd_end_c;
  logic [RAM_AW-1:0] ram_idx_c;
  logic [DATA_W-1:0] rd_val_c;

  // Decode strobes; r_n=w_n=0 together is neither a read nor a write.
  assign rd_act_c = !hpi_cs_n && !hpi_r_n &&  hpi_w_n;
  assign wr_act_c = !hpi_cs_n && !hpi_w_n &&  hpi_r_n;

  // lock_q suppresses a strobe that was already held across a reset until it
  // has been released once.
  assign access_ok_c = hpi_rst_n && !lock_q;
  assign rd_edge_c   = access_ok_c && rd_act_c && !rd_q;
  assign wr_edge_c   = access_ok_c && wr_act_c && !wr_q;
  assign rd_end_c    = hpi_data_oe && !rd_act_c;

  // Bit 0 and bits [15:11] of ADDRESS are ignored, so the RAM aliases.
  assign ram_idx_c = address_q[RAM_AW:1];

  // Read value mux, captured on the strobe edge.
  always_comb begin
    rd_val_c = '0;
    case (hpi_addr)
      REG_DATA:   rd_val_c = ram[ram_idx_c];
      REG_MBX:    rd_val_c = mbx_out_q;
      REG_ADDR:   rd_val_c = address_q;
      REG_STATUS: rd_val_c = {14'd0, mbx_in_valid, out_flag_q};
      default:    rd_val_c = '0;
    endcase
  end

  // RAM write port; contents survive both resets.
  always_ff @(posedge clk) begin
    if (reset_n && wr_edge_c && (hpi_addr == REG_DATA)) begin
      ram[ram_idx_c] <= hpi_data_in;
    end
  end

`ifdef HPI_AUTOINC_EN
  logic wr_commit_q;

  // Marks the cycle after a DATA write commit for the address increment.
  always_ff @(posedge clk) begin
    if (!reset_n || !hpi_rst_n) begin
      wr_commit_q <= 1'b0;
    end else begin
      wr_commit_q <= wr_edge_c && (hpi_addr == REG_DATA);
    end
  end
`endif

  // Strobe history, read port, mailboxes and address pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      lock_q       <= rd_act_c || wr_act_c;
      rd_sel_q     <= REG_DATA;
      hpi_data_out <= 16'h0000;
      hpi_data_oe  <= 1'b0;
      mbx_in_data  <= 16'h0000;
      mbx_in_valid <= 1'b0;
      mbx_out_q    <= 16'h0000;
      out_flag_q   <= 1'b0;
      address_q    <= 16'h0000;
    end else begin
      rd_q <= rd_act_c;
      wr_q <= wr_act_c;
      if (!rd_act_c && !wr_act_c) begin
        lock_q <= 1'b0;
      end

      // Read data appears the cycle after the edge and holds until release.
      if (rd_edge_c) begin
        hpi_data_out <= rd_val_c;
        hpi_data_oe  <= 1'b1;
        rd_sel_q     <= hpi_addr;
      end else if (!rd_act_c) begin
        hpi_data_oe <= 1'b0;
      end

      // Inbound mailbox: a host write beats a simultaneous ack.
      if (wr_edge_c && (hpi_addr == REG_MBX)) begin
        mbx_in_data  <= hpi_data_in;
        mbx_in_valid <= 1'b1;
      end else if (mbx_in_ack) begin
        mbx_in_valid <= 1'b0;
      end

      // Outbound mailbox: a local load beats the read-end clear.
      if (mbx_out_wr) begin
        mbx_out_q  <= mbx_out_data;
        out_flag_q <= 1'b1;
      end else if (rd_end_c && (rd_sel_q == REG_MBX)) begin
        out_flag_q <= 1'b0;
      end

      if (wr_edge_c && (hpi_addr == REG_ADDR)) begin
        address_q <= hpi_data_in;
      end
`ifdef HPI_AUTOINC_EN
      else if (wr_commit_q || (rd_end_c && (rd_sel_q == REG_DATA))) begin
        address_q <= address_q + 16'd2;
      end
`endif

      // Host-side reset aborts the access and clears the host-visible state.
      if (!hpi_rst_n) begin
        lock_q       <= rd_act_c || wr_act_c;
        hpi_data_oe  <= 1'b0;
        mbx_in_valid <= 1'b0;
        out_flag_q   <= 1'b0;
        address_q    <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_hpi_responder.sv
module tb_hpi_responder;

`ifdef HPI_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk;
  logic        reset_n;
  logic [1:0]  hpi_addr;
  logic        hpi_cs_n, hpi_r_n, hpi_w_n, hpi_rst_n;
  logic [15:0] hpi_data_in;
  logic [15:0] hpi_data_out;
  logic        hpi_data_oe;
  logic [15:0] mbx_in_data;
  logic        mbx_in_valid;
  logic        mbx_in_ack;
  logic [15:0] mbx_out_data;
  logic        mbx_out_wr;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q [$];

  hpi_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hpi_addr     (hpi_addr),
    .hpi_cs_n     (hpi_cs_n),
    .hpi_r_n      (hpi_r_n),
    .hpi_w_n      (hpi_w_n),
    .hpi_rst_n    (hpi_rst_n),
    .hpi_data_in  (hpi_data_in),
    .hpi_data_out (hpi_data_out),
    .hpi_data_oe  (hpi_data_oe),
    .mbx_in_data  (mbx_in_data),
    .mbx_in_valid (mbx_in_valid),
    .mbx_in_ack   (mbx_in_ack),
    .mbx_out_data (mbx_out_data),
    .mbx_out_wr   (mbx_out_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    hpi_cs_n = 1'b1;
    hpi_r_n  = 1'b1;
    hpi_w_n  = 1'b1;
  endtask

  task automatic host_write(input logic [1:0] a, input logic [15:0] d);
    hpi_addr = a; hpi_data_in = d;
    hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_r_n = 1'b1;
    cyc(2);
    idle();
    cyc(2);
  endtask

  // Push the expectation, strobe, wait (bounded) for oe, pop and compare.
  task automatic host_read(input logic [1:0] a, input logic [15:0] exp, input string nm,
                           input int hold, input logic wr_end, input logic [15:0] wr_val);
    int lat;
    logic [15:0] e;
    exp_q.push_back(exp);
    hpi_addr = a;
    hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b1;
    lat = 0;
    do begin
      cyc(1);
      lat++;
    end while (hpi_data_oe !== 1'b1 && lat < 4);
    n_cmp++;
    if (lat != 1 || hpi_data_oe !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: got %0d cycles oe=%b, want 1 cycle oe=1", nm, lat, hpi_data_oe);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (hpi_data_out !== e) begin
      n_err++;
      $display("FAIL %s_data: got %h, want %h", nm, hpi_data_out, e);
    end
    if (hold > 1) begin
      cyc(hold - 1);
      n_cmp++;
      if (hpi_data_oe !== 1'b1 || hpi_data_out !== e) begin
        n_err++;
        $display("FAIL %s_hold: got oe=%b data=%h, want oe=1 data=%h", nm, hpi_data_oe, hpi_data_out, e);
      end
    end
    idle();
    mbx_out_wr = wr_end; mbx_out_data = wr_val;
    cyc(1);
    mbx_out_wr = 1'b0;
    n_cmp++;
    if (hpi_data_oe !== 1'b0) begin
      n_err++;
      $display("FAIL %s_release: got oe=%b, want 0", nm, hpi_data_oe);
    end
    cyc(1);
  endtask

  task automatic rd(input logic [1:0] a, input logic [15:0] exp, input string nm);
    host_read(a, exp, nm, 1, 1'b0, 16'h0000);
  endtask

  task automatic test_reset();
    idle();
    hpi_rst_n = 1'b1; mbx_in_ack = 1'b0; mbx_out_wr = 1'b0;
    mbx_out_data = 16'h0000; hpi_addr = A_DATA; hpi_data_in = 16'h0000;
    reset_n = 1'b0;
    cyc(3);
    n_cmp++;
    if (hpi_data_oe !== 1'b0 || hpi_data_out !== 16'h0000 || mbx_in_data !== 16'h0000 || mbx_in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got oe=%b out=%h in_data=%h in_valid=%b, want 0/0000/0000/0",
               hpi_data_oe, hpi_data_out, mbx_in_data, mbx_in_valid);
    end
    reset_n = 1'b1;
    cyc(1);
    rd(A_ADDR, 16'h0000, "reset_address");
    rd(A_STAT, 16'h0000, "reset_status");
  endtask

  task automatic test_data_rw();
    host_write(A_ADDR, 16'h0100);
    host_write(A_DATA, 16'hBEEF);
    host_write(A_ADDR, 16'h0100);
    host_read(A_DATA, 16'hBEEF, "data_rd", 4, 1'b0, 16'h0000);
    rd(A_ADDR, AUTOINC ? 16'h0102 : 16'h0100, "addr_after_data_rd");
  endtask

  task automatic test_autoinc_alias();
    host_write(A_ADDR, 16'h0000);
    host_write(A_DATA, 16'h0A0A);
    host_write(A_ADDR, 16'hFFFE);
    host_write(A_DATA, 16'h1111);
    host_write(A_DATA, 16'h2222);
    rd(A_ADDR, AUTOINC ? 16'h0002 : 16'hFFFE, "wrap_address");
    host_write(A_ADDR, 16'h07FF);
    rd(A_DATA, AUTOINC ? 16'h1111 : 16'h2222, "alias_ram1023");
    host_write(A_ADDR, 16'hF800);
    rd(A_DATA, AUTOINC ? 16'h2222 : 16'h0A0A, "alias_ram0");
  endtask

  task automatic test_held_strobe();
    host_write(A_ADDR, 16'h0202);
    host_write(A_DATA, 16'h7777);
    host_write(A_ADDR, 16'h0200);
    hpi_addr = A_DATA; hpi_data_in = 16'h4444;
    hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_r_n = 1'b1;
    cyc(1);
    hpi_data_in = 16'h5555;
    cyc(9);
    idle();
    cyc(2);
    rd(A_ADDR, AUTOINC ? 16'h0202 : 16'h0200, "held_addr");
    host_write(A_ADDR, 16'h0200);
    rd(A_DATA, 16'h4444, "held_ram");
    host_write(A_ADDR, 16'h0202);
    rd(A_DATA, 16'h7777, "held_neighbour");
  endtask

  task automatic test_mbx_in();
    hpi_addr = A_MBX; hpi_data_in = 16'h00A5;
    hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_r_n = 1'b1;
    mbx_in_ack = 1'b1;
    cyc(1);
    mbx_in_ack = 1'b0;
    cyc(1);
    idle();
    cyc(1);
    n_cmp++;
    if (mbx_in_valid !== 1'b1 || mbx_in_data !== 16'h00A5) begin
      n_err++;
      $display("FAIL mbx_in_write_vs_ack: got valid=%b data=%h, want 1/00a5", mbx_in_valid, mbx_in_data);
    end
    rd(A_STAT, 16'h0002, "status_in_valid");
    mbx_in_ack = 1'b1;
    cyc(1);
    mbx_in_ack = 1'b0;
    cyc(1);
    n_cmp++;
    if (mbx_in_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mbx_in_ack: got valid=%b, want 0", mbx_in_valid);
    end
    rd(A_STAT, 16'h0000, "status_after_ack");
  endtask

  task automatic test_mbx_out();
    mbx_out_data = 16'h1234; mbx_out_wr = 1'b1;
    cyc(1);
    mbx_out_wr = 1'b0;
    cyc(1);
    rd(A_STAT, 16'h0001, "status_out_set");
    rd(A_MBX, 16'h1234, "mbx_out_rd");
    rd(A_STAT, 16'h0000, "status_out_clr");
    mbx_out_data = 16'h9999; mbx_out_wr = 1'b1;
    cyc(1);
    mbx_out_wr = 1'b0;
    cyc(1);
    host_read(A_MBX, 16'h9999, "mbx_out_rd2", 2, 1'b1, 16'h5678);
    rd(A_STAT, 16'h0001, "status_wr_wins");
    rd(A_MBX, 16'h5678, "mbx_out_new");
    rd(A_STAT, 16'h0000, "status_out_clr2");
  endtask

  task automatic test_conflict_hpi_rst();
    host_write(A_ADDR, 16'h0100);
    hpi_addr = A_DATA; hpi_data_in = 16'hDEAD;
    hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_cmp++;
      if (hpi_data_oe !== 1'b0) begin
        n_err++;
        $display("FAIL conflict_oe: got oe=%b at cycle %0d, want 0", hpi_data_oe, i);
      end
    end
    idle();
    cyc(1);
    rd(A_ADDR, 16'h0100, "conflict_addr");
    rd(A_DATA, 16'hBEEF, "conflict_ram");
    mbx_out_data = 16'h0042; mbx_out_wr = 1'b1;
    cyc(1);
    mbx_out_wr = 1'b0;
    host_write(A_MBX, 16'h0001);
    host_write(A_ADDR, 16'h0300);
    rd(A_STAT, 16'h0003, "status_both");
    hpi_rst_n = 1'b0;
    cyc(2);
    hpi_rst_n = 1'b1;
    cyc(1);
    rd(A_ADDR, 16'h0000, "hpi_rst_addr");
    rd(A_STAT, 16'h0000, "hpi_rst_status");
    host_write(A_ADDR, 16'h0100);
    rd(A_DATA, 16'hBEEF, "hpi_rst_ram_kept");
  endtask

  task automatic test_reset_during_strobe();
    host_write(A_ADDR, 16'h0000);
    hpi_addr = A_DATA; hpi_data_in = 16'hDEAD;
    hpi_cs_n = 1'b0; hpi_w_n = 1'b0; hpi_r_n = 1'b1;
    cyc(1);
    reset_n = 1'b0;
    hpi_data_in = 16'hF00D;
    cyc(2);
    reset_n = 1'b1;
    cyc(3);
    idle();
    cyc(2);
    rd(A_ADDR, 16'h0000, "rst_hold_addr");
    rd(A_DATA, 16'hDEAD, "rst_hold_ram");
    hpi_addr = A_STAT;
    hpi_cs_n = 1'b0; hpi_r_n = 1'b0; hpi_w_n = 1'b1;
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_cmp++;
      if (hpi_data_oe !== 1'b0) begin
        n_err++;
        $display("FAIL rst_hold_read_oe: got oe=%b at cycle %0d, want 0", hpi_data_oe, i);
      end
    end
    idle();
    cyc(1);
    rd(A_STAT, 16'h0000, "rst_rearm_read");
  endtask

  initial begin
    test_reset();
    test_data_rw();
    test_autoinc_alias();
    test_held_strobe();
    test_mbx_in();
    test_mbx_out();
    test_conflict_hpi_rst();
    test_reset_during_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
